// File: rtl/am29xx_slice_pair.sv
// rtl/am29xx_slice_pair.sv - Am2901 ALU slice plus Am2909/2911 sequencer slice
// Optional shift I/O ports are enabled by defining AM29XX_SHIFT_IO_EN.
module am29xx_slice_pair #(
  parameter int SEQ_2911 = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] alu_d,
  input  logic [3:0] alu_a,
  input  logic [3:0] alu_b,
  input  logic [2:0] alu_src,
  input  logic [2:0] alu_op,
  input  logic [2:0] alu_dest,
  input  logic       alu_cin,
`ifdef AM29XX_SHIFT_IO_EN
  input  logic       alu_sin_up,
  input  logic       alu_sin_dn,
  output logic       alu_sout_up,
  output logic       alu_sout_dn,
`endif
  output logic [3:0] alu_y,
  output logic       alu_cout,
  output logic       alu_fz,
  output logic       alu_f3,
  output logic       alu_ovr,
  input  logic [3:0] seq_d,
  input  logic [3:0] seq_r,
  input  logic [3:0] seq_or,
  input  logic       seq_s0,
  input  logic       seq_s1,
  input  logic       seq_zero_n,
  input  logic       seq_cin,
  input  logic       seq_re_n,
  input  logic       seq_fe_n,
  input  logic       seq_pup,
  output logic [3:0] seq_y,
  output logic       seq_cout
);

  logic [3:0] ram [16];
  logic [3:0] q;
  logic [3:0] a_val, b_val, r, s, r_op, s_op, f;
  logic [4:0] sum;
  logic [3:0] low_sum;
  logic       arith;
  logic       fill_up, fill_dn;

  assign a_val = ram[alu_a];
  assign b_val = ram[alu_b];

`ifdef AM29XX_SHIFT_IO_EN
  assign fill_up     = alu_sin_up;
  assign fill_dn     = alu_sin_dn;
  assign alu_sout_up = f[3];
  assign alu_sout_dn = f[0];
`else
  assign fill_up = 1'b0;
  assign fill_dn = 1'b0;
`endif

  always_comb begin
    r = 4'h0;
    s = 4'h0;
    case (alu_src)
      3'd0: begin r = a_val; s = q;     end
      3'd1: begin r = a_val; s = b_val; end
      3'd2: begin r = 4'h0;  s = q;     end
      3'd3: begin r = 4'h0;  s = b_val; end
      3'd4: begin r = 4'h0;  s = a_val; end
      3'd5: begin r = alu_d; s = a_val; end
      3'd6: begin r = alu_d; s = q;     end
      default: begin r = alu_d; s = 4'h0; end
    endcase
  end

  // Subtractions are R/S inverted into a plain adder; low_sum[3] is the carry into bit 3.
  always_comb begin
    r_op  = r;
    s_op  = s;
    arith = (alu_op <= 3'd2);
    if (alu_op == 3'd1) r_op = ~r;
    if (alu_op == 3'd2) s_op = ~s;
    sum     = {1'b0, r_op} + {1'b0, s_op} + {4'b0, alu_cin};
    low_sum = {1'b0, r_op[2:0]} + {1'b0, s_op[2:0]} + {3'b0, alu_cin};
    case (alu_op)
      3'd3:    f = r | s;
      3'd4:    f = r & s;
      3'd5:    f = ~r & s;
      3'd6:    f = r ^ s;
      3'd7:    f = ~(r ^ s);
      default: f = sum[3:0];
    endcase
  end

  assign alu_cout = arith & sum[4];
  assign alu_ovr  = arith & (low_sum[3] ^ sum[4]);
  assign alu_fz   = (f == 4'h0);
  assign alu_f3   = f[3];
  assign alu_y    = (alu_dest == 3'd2) ? a_val : f;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= 4'h0;
      q <= 4'h0;
    end else begin
      case (alu_dest)
        3'd0: q <= f;
        3'd2, 3'd3: ram[alu_b] <= f;
        3'd4: begin ram[alu_b] <= {fill_dn, f[3:1]}; q <= {fill_dn, q[3:1]}; end
        3'd5: ram[alu_b] <= {fill_dn, f[3:1]};
        3'd6: begin ram[alu_b] <= {f[2:0], fill_up}; q <= {q[2:0], fill_up}; end
        3'd7: ram[alu_b] <= {f[2:0], fill_up};
        default: ;
      endcase
    end
  end

  logic [3:0] upc, ar, mux, or_eff, ar_src;
  logic [3:0] stk [4];
  logic [1:0] sp;

  assign or_eff = (SEQ_2911 != 0) ? 4'h0 : seq_or;
  assign ar_src = (SEQ_2911 != 0) ? seq_d : seq_r;

  always_comb begin
    case ({seq_s1, seq_s0})
      2'd0:    mux = upc;
      2'd1:    mux = ar;
      2'd2:    mux = stk[sp];
      default: mux = seq_d;
    endcase
  end

  assign seq_y    = seq_zero_n ? (mux | or_eff) : 4'h0;
  assign seq_cout = seq_cin & (seq_y == 4'hF);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      upc <= 4'h0;
      ar  <= 4'h0;
      sp  <= 2'd0;
      for (int i = 0; i < 4; i++) stk[i] <= 4'h0;
    end else begin
      upc <= seq_y + {3'b0, seq_cin};
      if (!seq_re_n) ar <= ar_src;
      if (!seq_fe_n) begin
        if (seq_pup) begin
          sp           <= sp + 2'd1;
          stk[sp + 2'd1] <= upc;
        end else begin
          sp <= sp - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_am29xx_slice_pair.sv
// tb/tb_am29xx_slice_pair.sv - randomized bench against an arithmetic reference model
module tb_am29xx_slice_pair;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] alu_d = '0, alu_a = '0, alu_b = '0;
  logic [2:0] alu_src = '0, alu_op = '0, alu_dest = '0;
  logic       alu_cin = 1'b0;
  logic [3:0] seq_d = '0, seq_r = '0, seq_or = '0;
  logic       seq_s0 = 1'b0, seq_s1 = 1'b0, seq_zero_n = 1'b1, seq_cin = 1'b0;
  logic       seq_re_n = 1'b1, seq_fe_n = 1'b1, seq_pup = 1'b0;
  logic [3:0] alu_y, alu_y1, seq_y, seq_y1;
  logic       alu_cout, alu_fz, alu_f3, alu_ovr, seq_cout;
  logic       alu_cout1, alu_fz1, alu_f31, alu_ovr1, seq_cout1;

  int total = 0;
  int bad = 0;

  am29xx_slice_pair #(.SEQ_2911(0)) dut (
    .clock(clock), .reset(reset), .alu_d(alu_d), .alu_a(alu_a), .alu_b(alu_b),
    .alu_src(alu_src), .alu_op(alu_op), .alu_dest(alu_dest), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_fz(alu_fz), .alu_f3(alu_f3), .alu_ovr(alu_ovr),
    .seq_d(seq_d), .seq_r(seq_r), .seq_or(seq_or), .seq_s0(seq_s0), .seq_s1(seq_s1),
    .seq_zero_n(seq_zero_n), .seq_cin(seq_cin), .seq_re_n(seq_re_n), .seq_fe_n(seq_fe_n),
    .seq_pup(seq_pup), .seq_y(seq_y), .seq_cout(seq_cout));

  am29xx_slice_pair #(.SEQ_2911(1)) dut_2911 (
    .clock(clock), .reset(reset), .alu_d(alu_d), .alu_a(alu_a), .alu_b(alu_b),
    .alu_src(alu_src), .alu_op(alu_op), .alu_dest(alu_dest), .alu_cin(alu_cin),
    .alu_y(alu_y1), .alu_cout(alu_cout1), .alu_fz(alu_fz1), .alu_f3(alu_f31), .alu_ovr(alu_ovr1),
    .seq_d(seq_d), .seq_r(seq_r), .seq_or(seq_or), .seq_s0(seq_s0), .seq_s1(seq_s1),
    .seq_zero_n(seq_zero_n), .seq_cin(seq_cin), .seq_re_n(seq_re_n), .seq_fe_n(seq_fe_n),
    .seq_pup(seq_pup), .seq_y(seq_y1), .seq_cout(seq_cout1));

  always #5 clock = ~clock;

  int m_ram [16];
  int m_q;
  int m_upc [2], m_ar [2], m_sp [2];
  int m_stk [2][4];
  int e_f, e_y, e_cout, e_fz, e_f3, e_ovr;
  int e_sy [2], e_scout [2];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int to_signed4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 0;
    m_q = 0;
    for (int k = 0; k < 2; k++) begin
      m_upc[k] = 0; m_ar[k] = 0; m_sp[k] = 0;
      for (int i = 0; i < 4; i++) m_stk[k][i] = 0;
    end
  endtask

  task automatic model_eval();
    int r, s, ra, sa, sum, sres, mux, orv;
    int a, b, d, cin;
    a = int'(alu_a); b = int'(alu_b); d = int'(alu_d); cin = int'(alu_cin);
    case (int'(alu_src))
      0: begin r = m_ram[a]; s = m_q;      end
      1: begin r = m_ram[a]; s = m_ram[b]; end
      2: begin r = 0;        s = m_q;      end
      3: begin r = 0;        s = m_ram[b]; end
      4: begin r = 0;        s = m_ram[a]; end
      5: begin r = d;        s = m_ram[a]; end
      6: begin r = d;        s = m_q;      end
      default: begin r = d;  s = 0;        end
    endcase
    e_cout = 0;
    e_ovr = 0;
    if (alu_op <= 3'd2) begin
      ra = (alu_op == 3'd1) ? 15 - r : r;
      sa = (alu_op == 3'd2) ? 15 - s : s;
      sum = ra + sa + cin;
      e_f = sum % 16;
      e_cout = (sum >= 16) ? 1 : 0;
      sres = to_signed4(ra) + to_signed4(sa) + cin;
      e_ovr = (sres > 7 || sres < -8) ? 1 : 0;
    end else begin
      case (int'(alu_op))
        3: e_f = r | s;
        4: e_f = r & s;
        5: e_f = (15 - r) & s;
        6: e_f = r ^ s;
        default: e_f = 15 - (r ^ s);
      endcase
    end
    e_y = (alu_dest == 3'd2) ? m_ram[a] : e_f;
    e_fz = (e_f == 0) ? 1 : 0;
    e_f3 = (e_f >= 8) ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      case ({seq_s1, seq_s0})
        2'd0: mux = m_upc[k];
        2'd1: mux = m_ar[k];
        2'd2: mux = m_stk[k][m_sp[k]];
        default: mux = int'(seq_d);
      endcase
      orv = (k == 1) ? 0 : int'(seq_or);
      e_sy[k] = seq_zero_n ? (mux | orv) : 0;
      e_scout[k] = (seq_cin && e_sy[k] == 15) ? 1 : 0;
    end
  endtask

  task automatic model_commit();
    int b, old_upc;
    b = int'(alu_b);
    case (int'(alu_dest))
      0: m_q = e_f;
      2, 3: m_ram[b] = e_f;
      4: begin m_ram[b] = e_f / 2; m_q = m_q / 2; end
      5: m_ram[b] = e_f / 2;
      6: begin m_ram[b] = (e_f * 2) % 16; m_q = (m_q * 2) % 16; end
      7: m_ram[b] = (e_f * 2) % 16;
      default: ;
    endcase
    for (int k = 0; k < 2; k++) begin
      old_upc = m_upc[k];
      m_upc[k] = (e_sy[k] + int'(seq_cin)) % 16;
      if (!seq_re_n) m_ar[k] = (k == 1) ? int'(seq_d) : int'(seq_r);
      if (!seq_fe_n) begin
        if (seq_pup) begin
          m_sp[k] = (m_sp[k] + 1) % 4;
          m_stk[k][m_sp[k]] = old_upc;
        end else begin
          m_sp[k] = (m_sp[k] + 3) % 4;
        end
      end
    end
  endtask

  task automatic compare_all();
    model_eval();
    check("alu_y", alu_y, e_y);
    check("alu_cout", alu_cout, e_cout);
    check("alu_fz", alu_fz, e_fz);
    check("alu_f3", alu_f3, e_f3);
    check("alu_ovr", alu_ovr, e_ovr);
    check("alu_y_2911", alu_y1, e_y);
    check("seq_y", seq_y, e_sy[0]);
    check("seq_cout", seq_cout, e_scout[0]);
    check("seq_y_2911", seq_y1, e_sy[1]);
    check("seq_cout_2911", seq_cout1, e_scout[1]);
  endtask

  task automatic step();
    #4;
    compare_all();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic set_alu(input int src, input int op, input int dest, input int a, input int b,
                         input int d, input int cin);
    alu_src = 3'(src); alu_op = 3'(op); alu_dest = 3'(dest);
    alu_a = 4'(a); alu_b = 4'(b); alu_d = 4'(d); alu_cin = 1'(cin);
  endtask

  task automatic set_seq(input int sel, input int d, input int r, input int orv, input int zn,
                         input int cin, input int re_n, input int fe_n, input int pup);
    {seq_s1, seq_s0} = 2'(sel); seq_d = 4'(d); seq_r = 4'(r); seq_or = 4'(orv);
    seq_zero_n = 1'(zn); seq_cin = 1'(cin); seq_re_n = 1'(re_n); seq_fe_n = 1'(fe_n);
    seq_pup = 1'(pup);
  endtask

  initial begin
    model_reset();
    #7;
    compare_all();
    reset = 1'b0;

    set_alu(7, 0, 3, 0, 5, 9, 0); step();
    set_alu(4, 0, 1, 5, 0, 0, 0); #1;
    check("dir_r5_y", alu_y, 9);
    check("dir_r5_fz", alu_fz, 0);
    step();

    set_alu(7, 0, 3, 0, 1, 7, 0); step();
    set_alu(7, 0, 3, 0, 2, 9, 0); step();
    set_alu(1, 0, 3, 1, 2, 0, 0); #1;
    check("dir_sum_y", alu_y, 0);
    check("dir_sum_cout", alu_cout, 1);
    check("dir_sum_fz", alu_fz, 1);
    step();
    set_alu(4, 0, 1, 2, 0, 0, 0); #1;
    check("dir_r2_zero", alu_y, 0);
    step();

    set_alu(7, 0, 0, 0, 0, 12, 0); step();
    set_alu(7, 0, 4, 0, 3, 8, 0); step();
    set_alu(4, 0, 1, 3, 0, 0, 0); #1;
    check("dir_r3_shift", alu_y, 4);
    step();
    set_alu(2, 0, 1, 0, 0, 0, 0); #1;
    check("dir_q_shift", alu_y, 6);
    step();
    set_alu(7, 0, 2, 3, 4, 11, 0); #1;
    check("dir_dest2_y", alu_y, 4);
    step();

    set_seq(3, 5, 0, 0, 1, 1, 1, 1, 0); #1;
    check("dir_seq_d", seq_y, 5);
    step();
    set_seq(0, 0, 0, 0, 1, 0, 1, 1, 0); #1;
    check("dir_seq_upc", seq_y, 6);
    step();
    set_seq(3, 9, 0, 0, 0, 1, 1, 1, 0); #1;
    check("dir_seq_zero", seq_y, 0);
    step();
    set_seq(0, 0, 0, 0, 1, 0, 1, 1, 0); #1;
    check("dir_seq_upc1", seq_y, 1);
    step();
    set_seq(3, 6, 0, 0, 1, 0, 1, 1, 0); step();
    set_seq(0, 0, 0, 0, 1, 0, 1, 0, 1); step();
    set_seq(2, 0, 0, 0, 1, 0, 1, 1, 0); #1;
    check("dir_seq_tos", seq_y, 6);
    step();
    set_seq(0, 0, 0, 0, 1, 0, 1, 0, 0); step();
    for (int i = 0; i < 5; i++) begin
      set_seq(3, i + 1, 0, 0, 1, 0, 1, 0, 1); step();
    end
    set_seq(2, 0, 0, 0, 1, 0, 1, 1, 0); step();
    set_seq(3, 3, 10, 0, 1, 0, 0, 1, 0); step();
    set_seq(1, 0, 0, 1, 1, 0, 1, 1, 0); #1;
    check("dir_ar_or", seq_y, 11);
    check("dir_ar_2911", seq_y1, 3);
    step();
    set_seq(3, 15, 0, 0, 1, 1, 1, 1, 0); #1;
    check("dir_cout", seq_cout, 1);
    step();

    for (int n = 0; n < 600; n++) begin
      set_alu(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
      set_seq(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0,
              ($urandom_range(0, 7) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      step();
    end

    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
